miriscv_lsu: RTL and testbench

- Load-store unit between the core's execute/memory stage and the data port of the on-chip RAM.
- Takes a core load/store request (address, size, store data) and generates RAM data-port signals: request, write enable, byte enables, word address, lane-replicated write data.
- Consumes RAM read data, which arrives one cycle after the request, and returns a byte/half/word aligned, sign/zero-extended result.
- Stalls the core for the duration of the access.

---
 rtl/miriscv_lsu.sv | 157 +++++++++++++++
 tb/tb_miriscv_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// Load-store unit: core load/store request to single-cycle-latency RAM data port.
// Optional misaligned-access detection when LSU_MISALIGN_EXC_EN is defined.
module miriscv_lsu (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
`ifdef LSU_MISALIGN_EXC_EN
    output logic        lsu_misalign_o,
`endif
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    function automatic size_e decode_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return SZ_B;
            3'b001, 3'b101: return SZ_H;
            default:        return SZ_W;  // 010 and the undefined encodings
        endcase
    endfunction

    state_e     state_q, state_d;
    size_e      size_q, size_d;
    logic [1:0] off_q, off_d;
    logic       uns_q, uns_d;
    logic       we_q, we_d;
    logic       mis_cur;
`ifdef LSU_MISALIGN_EXC_EN
    logic       mis_q, mis_d;
`endif

    size_e       req_size;
    logic [4:0]  rd_shift;
    logic [31:0] rd_shifted;

    assign req_size   = decode_size(lsu_size_i);
    assign rd_shift   = (size_q == SZ_H) ? {off_q[1], 4'b0000} : {off_q, 3'b000};
    assign rd_shifted = data_rdata_i >> rd_shift;

`ifdef LSU_MISALIGN_EXC_EN
    assign mis_cur = ((req_size == SZ_H) && lsu_addr_i[0]) ||
                     ((req_size == SZ_W) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign mis_cur = 1'b0;
`endif

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        size_d          = size_q;
        off_d           = off_q;
        uns_d           = uns_q;
        we_d            = we_q;
`ifdef LSU_MISALIGN_EXC_EN
        mis_d           = mis_q;
        lsu_misalign_o  = 1'b0;
`endif
        lsu_data_o      = 32'h0;
        lsu_stall_req_o = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0000;
        data_addr_o     = 32'h0;
        data_wdata_o    = 32'h0;

        // Outputs are combinational, so they are forced to zero while reset is held.
        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (lsu_req_i) begin
                        lsu_stall_req_o = 1'b1;
                        data_req_o      = ~mis_cur;
                        data_we_o       = lsu_we_i & ~mis_cur;
                        data_addr_o     = {lsu_addr_i[31:2], 2'b00};
                        data_be_o       = 4'b1111;
                        if (lsu_we_i) begin
                            case (req_size)
                                SZ_B: begin
                                    data_be_o    = 4'b0001 << lsu_addr_i[1:0];
                                    data_wdata_o = {4{lsu_data_i[7:0]}};
                                end
                                SZ_H: begin
                                    data_be_o    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                                    data_wdata_o = {2{lsu_data_i[15:0]}};
                                end
                                default: data_wdata_o = lsu_data_i;
                            endcase
                        end
                        size_d  = req_size;
                        off_d   = lsu_addr_i[1:0];
                        uns_d   = lsu_size_i[2];
                        we_d    = lsu_we_i;
`ifdef LSU_MISALIGN_EXC_EN
                        mis_d   = mis_cur;
`endif
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
`ifdef LSU_MISALIGN_EXC_EN
                    lsu_misalign_o = mis_q;
                    if (!we_q && !mis_q) begin
`else
                    if (!we_q) begin
`endif
                        case (size_q)
                            SZ_B:    lsu_data_o = {{24{~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
                            SZ_H:    lsu_data_o = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
                            default: lsu_data_o = data_rdata_i;
                        endcase
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            size_q  <= SZ_W;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
`ifdef LSU_MISALIGN_EXC_EN
            mis_q   <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu with a behavioural 1-cycle RAM
// and a queue of expected load results popped in each WAIT cycle.
module tb_miriscv_lsu;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'b010;
    logic [31:0] lsu_addr_i = 32'h0;
    logic [31:0] lsu_data_i = 32'h0;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
`ifdef LSU_MISALIGN_EXC_EN
    logic        lsu_misalign_o;
`endif
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    miriscv_lsu dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
`ifdef LSU_MISALIGN_EXC_EN
        .lsu_misalign_o  (lsu_misalign_o),
`endif
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 64 words, byte-enable writes, read data one cycle later.
    logic [31:0] mem [0:63];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8000_00F0;
            loaded <= 1'b1;
        end else if (data_req_o) begin
            if (data_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (data_be_o[b]) mem[data_addr_o[7:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
            end else begin
                data_rdata_i <= mem[data_addr_o[7:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request in IDLE and check the RAM-side outputs of that cycle.
    task automatic issue(input string tag, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_req, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_res);
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wdata;
        exp_q.push_back(exp_res);
        @(negedge clk);
        check({tag, ".req"},   {31'h0, data_req_o}, {31'h0, exp_req});
        check({tag, ".we"},    {31'h0, data_we_o},  {31'h0, exp_req & we});
        check({tag, ".stall"}, {31'h0, lsu_stall_req_o}, 32'h1);
        check({tag, ".addr"},  data_addr_o, {addr[31:2], 2'b00});
        if (exp_req) check({tag, ".be"}, {28'h0, data_be_o}, {28'h0, exp_be});
        if (we)      check({tag, ".wdata"}, data_wdata_o, exp_wd);
        @(posedge clk);
        #1;
    endtask

    // WAIT cycle: pop the expected result and compare.
    task automatic finish_wait(input string tag, input bit hold, input logic exp_mis);
        logic [31:0] exp;
        if (!hold) lsu_req_i = 1'b0;
        @(negedge clk);
        check({tag, ".w_req"},   {31'h0, data_req_o}, 32'h0);
        check({tag, ".w_stall"}, {31'h0, lsu_stall_req_o}, 32'h0);
        check({tag, ".sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, ".data"}, lsu_data_o, exp);
        end
`ifdef LSU_MISALIGN_EXC_EN
        check({tag, ".mis"}, {31'h0, lsu_misalign_o}, {31'h0, exp_mis});
`else
        if (exp_mis) check({tag, ".mis_unexpected"}, 32'h1, 32'h0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.data",  lsu_data_o, 32'h0);
        check("rst.stall", {31'h0, lsu_stall_req_o}, 32'h0);
        check("rst.req",   {31'h0, data_req_o}, 32'h0);
        check("rst.be",    {28'h0, data_be_o}, 32'h0);
        check("rst.addr",  data_addr_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle.req",  {31'h0, data_req_o}, 32'h0);
        check("idle.data", lsu_data_o, 32'h0);
        @(posedge clk);
        #1;

        issue("lb", 1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hFFFF_FFF0);
        finish_wait("lb", 1'b0, 1'b0);
        issue("lbu", 1'b0, 3'b100, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0000_00F0);
        finish_wait("lbu", 1'b0, 1'b0);

        issue("sb", 1'b1, 3'b000, 32'h13, 32'h1234_56AB, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0);
        finish_wait("sb", 1'b0, 1'b0);
        issue("lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hAB00_00F0);
        finish_wait("lw", 1'b0, 1'b0);

        issue("sh1", 1'b1, 3'b001, 32'h22, 32'h0000_1234, 1'b1, 4'b1100, 32'h1234_1234, 32'h0);
        finish_wait("sh1", 1'b0, 1'b0);
        issue("sh2", 1'b1, 3'b001, 32'h22, 32'h5555_9234, 1'b1, 4'b1100, 32'h9234_9234, 32'h0);
        finish_wait("sh2", 1'b0, 1'b0);
        issue("lh", 1'b0, 3'b001, 32'h22, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hFFFF_9234);
        finish_wait("lh", 1'b0, 1'b0);
        issue("lhu", 1'b0, 3'b101, 32'h22, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0000_9234);
        finish_wait("lhu", 1'b0, 1'b0);
        issue("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h9234_0000);
        finish_wait("lw20", 1'b0, 1'b0);

        // Request held across WAIT cycles: req/stall must alternate 1,0,1,0,1,0.
        issue("b2b0", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hAB00_00F0);
        finish_wait("b2b0", 1'b1, 1'b0);
        issue("b2b1", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h9234_0000);
        finish_wait("b2b1", 1'b1, 1'b0);
        issue("b2b2", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hAB00_00F0);
        finish_wait("b2b2", 1'b0, 1'b0);

        issue("sz011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hAB00_00F0);
        finish_wait("sz011", 1'b0, 1'b0);

        // Reset pulse in WAIT: no result, outputs zero at once, next access normal.
        issue("rstw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0);
        void'(exp_q.pop_back());
        lsu_req_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rstw.data",  lsu_data_o, 32'h0);
        check("rstw.stall", {31'h0, lsu_stall_req_o}, 32'h0);
        check("rstw.req",   {31'h0, data_req_o}, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        issue("post", 1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h0000_00AB);
        finish_wait("post", 1'b0, 1'b0);

`ifdef LSU_MISALIGN_EXC_EN
        issue("swmis", 1'b1, 3'b010, 32'h21, 32'hCAFE_BABE, 1'b0, 4'b1111, 32'hCAFE_BABE, 32'h0);
        finish_wait("swmis", 1'b0, 1'b1);
        issue("lwchk", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h9234_0000);
        finish_wait("lwchk", 1'b0, 1'b0);
`else
        issue("swmis", 1'b1, 3'b010, 32'h21, 32'hCAFE_BABE, 1'b1, 4'b1111, 32'hCAFE_BABE, 32'h0);
        finish_wait("swmis", 1'b0, 1'b0);
        issue("lwchk", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hCAFE_BABE);
        finish_wait("lwchk", 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
